// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the rgb332 colour type and the 332 -> 888 expansion helpers.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam rgb332_t TP_WHITE   = 8'hFF;
  localparam rgb332_t TP_YELLOW  = 8'hFC;
  localparam rgb332_t TP_CYAN    = 8'h1F;
  localparam rgb332_t TP_GREEN   = 8'h1C;
  localparam rgb332_t TP_MAGENTA = 8'hE3;
  localparam rgb332_t TP_RED     = 8'hE0;
  localparam rgb332_t TP_BLUE    = 8'h03;
  localparam rgb332_t TP_BLACK   = 8'h00;

  // Bit replication keeps full-scale codes at exactly 8'h00 / 8'hFF.
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  function automatic rgb332_t test_bar(input logic [2:0] idx);
    case (idx)
      3'd0:    return TP_WHITE;
      3'd1:    return TP_YELLOW;
      3'd2:    return TP_CYAN;
      3'd3:    return TP_GREEN;
      3'd4:    return TP_MAGENTA;
      3'd5:    return TP_RED;
      3'd6:    return TP_BLUE;
      default: return TP_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset that loads every stage with RESET_VALUE.
module vga_delay_line #(
  parameter int                WIDTH       = 1,
  parameter int                DEPTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VALUE;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_output.sv
// 640x480@60 raster generator and final colour/sync output stage for the VGA DAC.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds testPatternSel).
module vga_timing_output
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  RGBIn,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        testPatternSel,
`endif
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        h_sync,
  output logic        v_sync,
  output logic        blank_n,
  output logic        sync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [10:0] x_q, x_d, y_q, y_d;
  logic        active_raw, hs_raw, vs_raw;
  logic [2:0]  sync_dly;
  rgb332_t     pix_c;
  logic [7:0]  red_q, green_q, blue_q;
  logic        hs_q, vs_q, blank_q;

  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == 11'(H_TOTAL - 1)) begin
      x_d = '0;
      y_d = (y_q == 11'(V_TOTAL - 1)) ? '0 : y_q + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign active_raw = (x_q < 11'(H_ACTIVE)) && (y_q < 11'(V_ACTIVE));
  assign hs_raw = !((x_q >= 11'(H_ACTIVE + H_FP)) && (x_q < 11'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw = !((y_q >= 11'(V_ACTIVE + V_FP)) && (y_q < 11'(V_ACTIVE + V_FP + V_SYNC)));

  // PIPE_DELAY stages here line timing up with RGBIn; the output register below is the final stage.
  vga_delay_line #(
    .WIDTH       (3),
    .DEPTH       (PIPE_DELAY),
    .RESET_VALUE (3'b110)
  ) u_sync_dly (
    .clk_i  (clk),
    .rst_i  (reset),
    .din_i  ({hs_raw, vs_raw, active_raw}),
    .dout_o (sync_dly)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] x_dly;
  logic [2:0] bar_idx;

  vga_delay_line #(
    .WIDTH       (10),
    .DEPTH       (PIPE_DELAY),
    .RESET_VALUE (10'd0)
  ) u_x_dly (
    .clk_i  (clk),
    .rst_i  (reset),
    .din_i  (x_q[9:0]),
    .dout_o (x_dly)
  );

  // Indices past the last bar only occur while blanked.
  assign bar_idx = 3'(x_dly / 10'(H_ACTIVE / 8));

  always_comb begin
    pix_c = rgb332_t'(RGBIn);
    if (testPatternSel) pix_c = test_bar(bar_idx);
  end
`else
  always_comb begin
    pix_c = rgb332_t'(RGBIn);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      hs_q    <= sync_dly[2];
      vs_q    <= sync_dly[1];
      blank_q <= sync_dly[0];
      if (sync_dly[0]) begin
        red_q   <= expand3(pix_c.r);
        green_q <= expand3(pix_c.g);
        blue_q  <= expand2(pix_c.b);
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end
    end
  end

  assign pixelX       = x_q;
  assign pixelY       = y_q;
  assign startOfFrame = (x_q == '0) && (y_q == '0);
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign h_sync       = hs_q;
  assign v_sync       = vs_q;
  assign blank_n      = blank_q;
  assign sync_n       = 1'b1;

endmodule

// File: doc/vga_timing_output.md
Name: vga_timing_output

Overview:
- Final video stage, directly downstream of the object priority mux.
- Generates 640x480@60 raster timing and issues pixelX/pixelY to all drawing objects.
- Receives the mux's registered 8-bit RRRGGGBB colour PIPE_DELAY cycles later and expands it to 8-8-8 for the VGA DAC.
- Delays sync and blank so they stay pixel-aligned with the colour, and forces black outside the active area.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync lines.
- V_BP, 33, vertical back porch.
- PIPE_DELAY, 1, clocks from pixelX/pixelY to matching RGBIn; legal range 1..4.

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal).
- reset  in  1  synchronous, active-high reset.
- RGBIn  in  8  colour from object mux, {R[2:0],G[2:0],B[1:0]}.
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1.
- pixelY  out  11  current vertical count, 0..V_TOTAL-1.
- startOfFrame  out  1  high for exactly the cycle where pixelX==0 and pixelY==0.
- red  out  8  expanded red to DAC.
- green  out  8  expanded green to DAC.
- blue  out  8  expanded blue to DAC.
- h_sync  out  1  active-low hsync, aligned with colour.
- v_sync  out  1  active-low vsync, aligned with colour.
- blank_n  out  1  low outside the active area, aligned with colour.
- sync_n  out  1  tied high (no sync-on-green).

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL computed likewise (525).
- Counters:
  - pixelX and pixelY are registered.
  - pixelX increments every clock and wraps H_TOTAL-1 -> 0.
  - pixelY increments only on the pixelX wrap and wraps V_TOTAL-1 -> 0.
  - At the last pixel of the frame, both counters wrap on the same edge.
- Raw timing, combinational from the counters:
  - active = (pixelX < H_ACTIVE) && (pixelY < V_ACTIVE).
  - hs_raw is low for H_ACTIVE+H_FP <= pixelX < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is low for the analogous pixelY range.
- Alignment:
  - {hs_raw, vs_raw, active} pass through a shift register of depth PIPE_DELAY+1.
  - red/green/blue are registered from RGBIn (one stage).
  - Result: colour that the mux produced for pixel (x,y) appears on the outputs on the same cycle as that pixel's sync/blank.
  - Total latency from the pixelX/pixelY value to the DAC outputs is PIPE_DELAY+1 clocks.
- Colour expansion, by bit replication:
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
  - 3'b111 -> 8'hFF, 3'b000 -> 8'h00, 2'b11 -> 8'hFF.
- Blanking: when the delayed active bit is 0, red/green/blue are registered as 8'h00 regardless of RGBIn.
- Reset values: pixelX=0, pixelY=0, red/green/blue=0, h_sync=1, v_sync=1, blank_n=0, sync_n=1. All delay-line stages load {1,1,0}.
- Reset mid-frame: counters restart at (0,0) on the first edge after reset falls. startOfFrame is high in that first cycle. No partial sync pulse is emitted while reset is high.
- RGBIn is don't-care during blanking and during the first PIPE_DELAY+1 cycles after reset.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input testPatternSel (1 bit).
  - While testPatternSel is high, RGBIn is ignored. The colour is 8 vertical bars of width H_ACTIVE/8, index = pixelX/80, taken from the delayed-X path.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bars use the same expansion and blanking as normal colour.
- When not defined: no port, no logic; RGBIn is always used.

Decomposition:
- Package vga_pkg holds:
  - default timing constants and H_TOTAL/V_TOTAL.
  - the rgb332 packed struct typedef.
  - function expand3/expand2.
  - the test-pattern colour constants.
- One sub-module, vga_delay_line: parameterised WIDTH/DEPTH/RESET_VALUE shift register with synchronous reset. Instantiated once for {hs, vs, active} and once for pixelX[9:0] under the macro.

Test Plan:
- Reset:
  - Hold reset 5 cycles: h_sync=1, v_sync=1, blank_n=0, RGB outputs=0.
  - Release: pixelX=0, pixelY=0, startOfFrame=1 in the first cycle.
- Line timing (PIPE_DELAY=1):
  - Line period is 800 clocks.
  - h_sync low for exactly 96 clocks, starting 2 clocks after pixelX reaches 656.
  - blank_n high for 640 clocks per visible line.
- Frame timing: startOfFrame pulses every 420000 clocks; v_sync low for 1600 clocks; pixelY wraps 524 -> 0.
- Colour expansion in the active area:
  - RGBIn=8'hE0 -> FF/00/00.
  - RGBIn=8'h03 -> 00/00/FF.
  - RGBIn=8'b10010110 -> red 8'h92, green 8'hB6, blue 8'hAA.
- Blanking: RGBIn=8'hFF held constant -> RGB=0 whenever blank_n=0, and FF/FF/FF when blank_n=1.
- Mid-frame reset and test pattern:
  - Assert reset at pixel (300,200): counters restart at (0,0), with no runt hsync.
  - With VGA_TEST_PATTERN_EN and testPatternSel=1:
    - pixels 0..79 output white.
    - pixels 80..159 output FF/FF/00.
    - pixels 560..639 output black.
